// File: rtl/dm_responder_if.sv
// dm_responder_if: request/response bus between the Memory stage and the
// data-memory responder.
//   req_valid/req_ready  request handshake (we, addr, be, wdata, pc)
//   rsp_valid/rsp_ready  response handshake (rdata, err)
// Modports: master = Memory stage, slave = responder.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with a fixed
// accept-to-response latency.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-low (0 = reset)
//   bus    dm_responder_if.slave (request/response handshakes)
// Parameters:
//   DEPTH_LOG2  log2 of word count (default 12 -> 4096 words)
//   LATENCY     accept-to-response cycles, 1..7 (default 2)
// Optional feature macro: DM_RESPONDER_WRITE_LOG_EN
//   When defined, each committed in-range store with nonzero byte enables
//   prints "@<pc>: *<byte addr> <= <merged word>" at the commit edge.
module dm_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [WORDS];

    logic [DEPTH_LOG2-1:0] idx_d;
    logic                  oor_d;
    logic [31:0]           merged_d;
    logic                  unused_d;

    // Access decode from the captured request: word index, range check, and
    // the stored word with enabled byte lanes replaced by store data.
    always_comb begin
        idx_d    = addr_q[DEPTH_LOG2+1:2];
        oor_d    = |addr_q[31:DEPTH_LOG2+2];
        merged_d = mem_q[idx_d];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Byte offset bits never select anything; pc only feeds the write log.
    assign unused_d = ^{addr_q[1:0], pc_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        be_q        <= bus.req_be;
                        wdata_q     <= bus.req_wdata;
                        pc_q        <= bus.req_pc;
                        cnt_q       <= 3'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 3'd0) begin
                        // Commit point: the store lands and the response is
                        // formed on this edge, so a reset before here drops it.
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= oor_d;
                        rsp_rdata_q <= (oor_d || we_q) ? 32'd0 : mem_q[idx_d];
                        if (!oor_d && we_q) begin
                            mem_q[idx_d] <= merged_d;
`ifdef DM_RESPONDER_WRITE_LOG_EN
                            if (be_q != 4'd0)
                                $display("@%08h: *%08h <= %08h", pc_q,
                                         {addr_q[31:2], 2'b00}, merged_d);
`endif
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized + directed bench for dm_responder.
// Three instances: main (LATENCY=2, DEPTH_LOG2=12) against a word-array
// reference model, plus LATENCY=1 and LATENCY=4 instances for timing and
// reset-abort scenarios.
module tb_dm_responder;
    localparam int LAT0 = 2;
    localparam int D0   = 12;
    localparam logic [31:0] LIM0 = 32'(1) << (D0 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst4;

    dm_responder_if b0 ();
    dm_responder_if b1 ();
    dm_responder_if b4 ();

    dm_responder #(.DEPTH_LOG2(D0), .LATENCY(LAT0)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
    dm_responder #(.DEPTH_LOG2(6),  .LATENCY(1))    dut1 (.clk(clk), .reset(rst1), .bus(b1));
    dm_responder #(.DEPTH_LOG2(6),  .LATENCY(4))    dut4 (.clk(clk), .reset(rst4), .bus(b4));

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [0:(1<<D0)-1];

    // LATENCY=1 scenario: req_valid held high, rsp_ready stalls one cycle.
    bit l1_rr [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit l1_er [7] = '{1, 0, 0, 0, 1, 0, 0};
    bit l1_ev [7] = '{0, 0, 1, 1, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One transaction on the main instance, checked against the word model.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int hold, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          w;
        int          n;
        exp_err = (addr >= LIM0);
        exp_rd  = '0;
        if (!exp_err) begin
            w = int'(addr >> 2);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
            end else begin
                exp_rd = ref_mem[w];
            end
        end
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = addr;
        b0.req_be = be; b0.req_wdata = wd; b0.req_pc = $urandom;
        n = 0;
        while (!b0.req_ready && n < 20) begin @(negedge clk); n++; end
        chk("accept_to", 32'(n < 20), 32'd1);
        @(negedge clk);
        // Scramble request fields: the responder must use captured values.
        b0.req_valid = 1'b0; b0.req_we = $urandom_range(0, 1); b0.req_addr = $urandom;
        b0.req_be = 4'($urandom); b0.req_wdata = $urandom;
        n = 0;
        while (!b0.rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("latency", 32'(n), 32'(LAT0));
        chk("rdata", b0.rsp_rdata, exp_rd);
        chk("err", 32'(b0.rsp_err), 32'(exp_err));
        got = b0.rsp_rdata;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_vld", 32'(b0.rsp_valid), 32'd1);
            chk("hold_rd", b0.rsp_rdata, exp_rd);
            chk("hold_err", 32'(b0.rsp_err), 32'(exp_err));
            chk("hold_rdy", 32'(b0.req_ready), 32'd0);
        end
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        chk("post_vld", 32'(b0.rsp_valid), 32'd0);
        chk("post_rdy", 32'(b0.req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        int          n;
        bit          seen;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        rst0 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
        b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_be = 0;
        b0.req_wdata = 0; b0.req_pc = 0; b0.rsp_ready = 0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0; b1.req_be = 0;
        b1.req_wdata = 0; b1.req_pc = 0; b1.rsp_ready = 0;
        b4.req_valid = 0; b4.req_we = 0; b4.req_addr = 0; b4.req_be = 0;
        b4.req_wdata = 0; b4.req_pc = 0; b4.rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;

        chk("rst_rdy", 32'(b0.req_ready), 32'd1);
        chk("rst_vld", 32'(b0.rsp_valid), 32'd0);
        chk("rst_rd", b0.rsp_rdata, 32'd0);
        chk("rst_err", 32'(b0.rsp_err), 32'd0);

        // Basic store/load, partial merge, out-of-range and boundary words.
        txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, got);
        txn(1'b0, 32'h10, 4'h0, 32'h0, 0, got);
        chk("full_word", got, 32'hDEAD_BEEF);
        txn(1'b1, 32'h10, 4'b0101, 32'h1122_3344, 0, got);
        txn(1'b0, 32'h10, 4'hF, 32'h0, 0, got);
        chk("merge", got, 32'hDE22_BE44);
        txn(1'b0, 32'h0001_0000, 4'hF, 32'h0, 0, got);
        txn(1'b1, 32'h0001_0010, 4'hF, 32'hFFFF_FFFF, 0, got);
        txn(1'b0, 32'h13, 4'h0, 32'h0, 0, got);
        chk("oor_no_write", got, 32'hDE22_BE44);
        txn(1'b1, LIM0 - 4, 4'hF, 32'hA5A5_0F0F, 0, got);
        txn(1'b0, LIM0 - 4, 4'hF, 32'h0, 0, got);
        txn(1'b0, LIM0, 4'hF, 32'h0, 0, got);
        txn(1'b1, 32'h10, 4'h0, 32'h0, 0, got);
        txn(1'b0, 32'h10, 4'hF, 32'h0, 5, got);

        // Randomized traffic over a small window plus occasional out-of-range.
        repeat (60) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom | LIM0;
            else addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 2), got);
        end

        // LATENCY=1: back-to-back loads with req_valid held through RESP.
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 32'h8; b1.req_be = 4'hF;
        for (int c = 0; c < 7; c++) begin
            b1.rsp_ready = l1_rr[c];
            chk("l1_rdy", 32'(b1.req_ready), 32'(l1_er[c]));
            chk("l1_vld", 32'(b1.rsp_valid), 32'(l1_ev[c]));
            if (l1_ev[c]) chk("l1_rd", b1.rsp_rdata, 32'd0);
            @(negedge clk);
        end
        b1.req_valid = 1'b0; b1.rsp_ready = 1'b0;
        chk("l1_end_rdy", 32'(b1.req_ready), 32'd1);

        // LATENCY=4: reset two cycles after a store is accepted.
        @(negedge clk);
        b4.req_valid = 1'b1; b4.req_we = 1'b1; b4.req_addr = 32'h20;
        b4.req_be = 4'hF; b4.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        b4.req_valid = 1'b0;
        chk("l4_acc", 32'(b4.req_ready), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            if (b4.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("l4_norsp", 32'(seen), 32'd0);
        chk("l4_rdy", 32'(b4.req_ready), 32'd1);
        b4.req_valid = 1'b1; b4.req_we = 1'b0;
        @(negedge clk);
        b4.req_valid = 1'b0;
        n = 0;
        while (!b4.rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("l4_lat", 32'(n), 32'd4);
        chk("l4_rd", b4.rsp_rdata, 32'd0);
        chk("l4_err", 32'(b4.rsp_err), 32'd0);
        b4.rsp_ready = 1'b1;
        @(negedge clk);
        b4.rsp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 12: log2 of the memory word count (4096 words, 16 KiB).
REQ-002 Parameter LATENCY, default 2: request-accept-to-response cycles, legal range 1..7.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset: 0 = reset asserted, sampled on the rising edge of clk.
REQ-005 req_valid  input  1  Memory-stage access request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 req_be  input  4  store byte-lane enables; bit i selects byte lane wdata[8i+7:8i].
REQ-010 req_wdata  input  32  store data.
REQ-011 req_pc  input  32  PC of the issuing instruction, used only by the write log.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  Memory stage consumes the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  address out of range.

Function
REQ-016 FSM states: IDLE, BUSY, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-017 IDLE: when req_valid is 1, the responder captures we/addr/be/wdata/pc, loads a counter with LATENCY-1, and moves to BUSY.
REQ-018 BUSY: the counter decrements each cycle; when the counter is 0, the access is performed and the state moves to RESP on the same edge.
REQ-019 Latency: a request accepted on edge k raises rsp_valid after edge k+LATENCY.
REQ-020 Access: word index = addr[DEPTH_LOG2+1:2]; out of range when addr[31:DEPTH_LOG2+2] != 0.
REQ-021 In-range store: only enabled byte lanes are written; be=4'b0000 is a no-op that still responds; rsp_rdata=0.
REQ-022 In-range load: rsp_rdata = full stored word, regardless of be.
REQ-023 Out of range: no write; rsp_rdata=0; rsp_err=1.
REQ-024 RESP: rsp_rdata and rsp_err are held stable until rsp_valid and rsp_ready are both 1; the state then returns to IDLE, so the next request is accepted one cycle later at the earliest.
REQ-025 A store is committed only at the BUSY-to-RESP edge; requests presented outside IDLE are ignored, not queued.
REQ-026 Load-after-store to the same address returns the newly written bytes merged with the old bytes.

Reset
REQ-027 On reset=0 at a clock edge: state=IDLE, counter=0, req_ready=1 afterwards, rsp_valid=0, rsp_rdata=0, rsp_err=0, all memory words=0.
REQ-028 Reset in BUSY or RESP: the pending access is discarded; an uncommitted store never writes; no response is produced.

Configuration
REQ-029 Macro DM_RESPONDER_WRITE_LOG_EN: when defined, each committed in-range store with nonzero be prints "@<pc>: *<byte addr> <= <merged word>" (hex, 8 digits) at the commit edge; when undefined, nothing is printed and the logic is identical otherwise.

Verification
REQ-030 Reset, then store addr=0x0000_0010, be=4'b1111, wdata=0xDEAD_BEEF; load 0x10 -> rsp_rdata=0xDEAD_BEEF, rsp_err=0, rsp_valid first high 2 cycles after accept.
REQ-031 Word 0x10=0xDEAD_BEEF; store be=4'b0101, wdata=0x1122_3344; load -> 0xDE22_BE44.
REQ-032 Load addr=0x0001_0000 (DEPTH_LOG2=12) -> rsp_err=1, rsp_rdata=0; memory unchanged.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; IDLE one cycle after handshake.
REQ-034 Store accepted with LATENCY=4; reset=0 asserted 2 cycles later -> no response; a later load of that address returns 0.
REQ-035 LATENCY=1: back-to-back loads -> each rsp_valid 1 cycle after its accept; a req_valid held during RESP is accepted only after the handshake.
